ram_8: RTL and testbench



---
 rtl/hack_pkg.sv | 10 +
 rtl/mux_8_way_16.sv | 31 +++
 rtl/register_16.sv | 25 ++
 rtl/ram_8.sv | 47 ++++
 tb/tb_ram_8.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared Hack datapath definitions: word width and RAM8 geometry.
package hack_pkg;

   localparam int unsigned WORD_WIDTH      = 16;
   localparam int unsigned RAM8_ADDR_WIDTH = 3;
   localparam int unsigned RAM8_DEPTH      = 8;

   typedef logic [15:0] word_t;

endpackage : hack_pkg

// File: rtl/mux_8_way_16.sv
// Eight-input 16-bit selector; sel 0..7 picks a..h.
module mux_8_way_16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   // Purely combinational select of one of eight words.
   always_comb begin
      out = '0;
      case (sel)
         3'd0: out = a;
         3'd1: out = b;
         3'd2: out = c;
         3'd3: out = d;
         3'd4: out = e;
         3'd5: out = f;
         3'd6: out = g;
         3'd7: out = h;
         default: out = '0;
      endcase
   end

endmodule : mux_8_way_16

// File: rtl/register_16.sv
// 16-bit register with synchronous active-high clear and load enable.
module register_16
   import hack_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out
);

   word_t value;

   // Clear on reset, capture on load, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= in;
      end
   end

   assign out = value;

endmodule : register_16

// File: rtl/ram_8.sv
// Eight-word by 16-bit register file: one-hot write decode, combinational read.
module ram_8
   import hack_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic [2:0]  address,
   output logic [15:0] out
);

   logic [RAM8_DEPTH-1:0] we;
   word_t                 words [RAM8_DEPTH];

   // One-hot write enable; reset suppresses any write presented with it.
   always_comb begin
      we = '0;
      if (load && !reset) begin
         we[address] = 1'b1;
      end
   end

   for (genvar k = 0; k < RAM8_DEPTH; k++) begin : g_word
      register_16 u_reg (
         .clk   (clk),
         .reset (reset),
         .load  (we[k]),
         .in    (in),
         .out   (words[k])
      );
   end

   mux_8_way_16 u_mux (
      .a   (words[0]),
      .b   (words[1]),
      .c   (words[2]),
      .d   (words[3]),
      .e   (words[4]),
      .f   (words[5]),
      .g   (words[6]),
      .h   (words[7]),
      .sel (address),
      .out (out)
   );

endmodule : ram_8

// File: tb/tb_ram_8.sv
// Self-checking bench for ram_8: directed steps plus randomized traffic against an array model.
module tb_ram_8;
   import hack_pkg::*;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] in;
   logic [2:0]  address;
   logic [15:0] out;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   word_t       model [8];
   word_t       pat   [8];

   ram_8 dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (load),
      .address (address),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t obs, input word_t exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check old value before the edge, new value after.
   task automatic cycle(input logic r, input logic l, input word_t d, input logic [2:0] a);
      @(negedge clk);
      reset = r; load = l; in = d; address = a;
      #1;
      check("pre_edge", out, model[a]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      end else if (l) begin
         model[a] = d;
      end
      #1;
      check("post_edge", out, model[a]);
   endtask

   // Read every address without a clock edge and compare to the model.
   task automatic sweep(input string tag);
      @(negedge clk);
      load = 1'b0; reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         check(tag, out, model[i]);
      end
   endtask

   initial begin
      pat[0] = 16'h5555; pat[1] = 16'hAAAA; pat[2] = 16'h00FF; pat[3] = 16'hFF00;
      pat[4] = 16'h3333; pat[5] = 16'hCCCC; pat[6] = 16'h0F0F; pat[7] = 16'hF0F0;

      // Initial reset: contents undefined before this edge.
      reset = 1'b1; load = 1'b0; in = 16'h0000; address = 3'd0;
      @(posedge clk);
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         check("reset_sweep", out, 16'h0000);
      end

      // Distinct pattern per word, then read back to show no aliasing.
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, pat[k], 3'(k));
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         check("pattern_sweep", out, pat[k]);
      end

      // Same-address read during write: old value before the edge, new after.
      @(negedge clk);
      address = 3'd2; in = 16'h1234; load = 1'b1;
      #1;
      check("rdw_before", out, 16'h00FF);
      @(posedge clk);
      model[2] = 16'h1234;
      #1;
      check("rdw_after", out, 16'h1234);

      // Write with load low must not disturb word 5.
      for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, 16'hFFFF, 3'd5);
      @(negedge clk);
      load = 1'b0; address = 3'd5;
      #1;
      check("noload_word5", out, 16'hCCCC);

      // Reset dominates a simultaneous write.
      cycle(1'b1, 1'b1, 16'hBEEF, 3'd7);
      @(negedge clk);
      reset = 1'b0; load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         address = 3'(i);
         #1;
         check("reset_over_load", out, 16'h0000);
      end

      // Combinational read follows address with no clock.
      cycle(1'b0, 1'b1, 16'hABCD, 3'd0);
      @(negedge clk);
      load = 1'b0;
      address = 3'd0; #1; check("comb_addr0", out, 16'hABCD);
      address = 3'd1; #1; check("comb_addr1", out, 16'h0000);
      address = 3'd0; #1; check("comb_addr0_again", out, 16'hABCD);

      // Randomized traffic against the array model.
      for (int n = 0; n < 400; n++) begin
         logic       r;
         logic       l;
         logic [2:0] a;
         word_t      d;
         r = ($urandom_range(31) == 0);
         l = $urandom_range(1);
         a = 3'($urandom_range(7));
         d = 16'($urandom);
         cycle(r, l, d, a);
         if ($urandom_range(3) == 0) begin
            address = 3'($urandom_range(7));
            load = 1'b0; reset = 1'b0;
            #1;
            check("rand_comb_read", out, model[address]);
         end
      end
      sweep("final_sweep");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ram_8
